// File: rtl/crc32_stream.sv
// crc32_stream: streaming Ethernet CRC-32 generator/checker.
// Folds up to DW/8 bytes per accepted beat into a reflected CRC-32 register
// and presents one result record (FCS, check verdict, byte count) per frame.
module crc32_stream #(
    parameter int unsigned DW      = 32,
    parameter logic [31:0] INIT    = 32'hFFFFFFFF,
    parameter logic [31:0] XOROUT  = 32'hFFFFFFFF,
    parameter logic [31:0] RESIDUE = 32'hDEBB20E3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [DW-1:0]   s_data,
    input  logic [DW/8-1:0] s_keep,
    input  logic            s_sof,
    input  logic            s_eof,
    input  logic            s_chk,
    output logic            o_valid,
    input  logic            o_ready,
    output logic [31:0]     o_crc,
    output logic            o_ok,
    output logic [15:0]     o_len
);

    localparam int unsigned NB   = DW / 8;
    localparam logic [31:0] POLY = 32'hEDB88320;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [31:0]   crc_q, crc_base, crc_next;
    logic [15:0]   len_q, len_base, len_next;
    logic [16:0]   len_sum, nbytes;
    logic          chk_q, chk_eff;
    logic [NB-1:0] lane_use;
    logic          keep_run;
    logic          accept, active, finish;

    // One reflected CRC-32 byte step, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int unsigned k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
        end
        return r;
    endfunction

    assign s_ready = !rst && (!o_valid || o_ready);
    assign o_valid = (state_q == DONE);
    assign accept  = s_valid && s_ready;
    // A beat belongs to a frame if it opens one or arrives while one is running.
    assign active  = accept && (s_sof || state_q == RUN);
    assign finish  = active && s_eof;

    // Lane selection: on EOF only lanes below the first cleared keep bit count.
    always_comb begin
        keep_run = 1'b1;
        lane_use = '1;
        nbytes   = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (s_eof) begin
                keep_run    = keep_run & s_keep[i];
                lane_use[i] = keep_run;
            end
            if (lane_use[i]) begin
                nbytes = nbytes + 17'd1;
            end
        end
    end

    // Combinational fold of the beat into the register and length counter.
    always_comb begin
        crc_base = s_sof ? INIT : crc_q;
        len_base = s_sof ? 16'd0 : len_q;
        chk_eff  = s_sof ? s_chk : chk_q;
        crc_next = crc_base;
        for (int unsigned i = 0; i < NB; i++) begin
            if (lane_use[i]) begin
                crc_next = crc_byte(crc_next, s_data[8*i +: 8]);
            end
        end
        len_sum  = {1'b0, len_base} + nbytes;
        len_next = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    end

    // Next-state logic; a SOF beat accepted while DONE is consumed restarts immediately.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && s_sof) state_d = s_eof ? DONE : RUN;
            end
            RUN: begin
                if (accept && s_eof) state_d = DONE;
            end
            DONE: begin
                if (o_ready) state_d = IDLE;
                if (accept && s_sof) state_d = s_eof ? DONE : RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, running CRC/length registers and held result record.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            crc_q   <= INIT;
            len_q   <= '0;
            chk_q   <= 1'b0;
            o_crc   <= '0;
            o_ok    <= 1'b0;
            o_len   <= '0;
        end else begin
            state_q <= state_d;
            if (active) begin
                crc_q <= crc_next;
                len_q <= len_next;
                chk_q <= chk_eff;
            end
            if (finish) begin
                o_crc <= crc_next ^ XOROUT;
                o_ok  <= chk_eff && (crc_next == RESIDUE);
                o_len <= len_next;
            end
        end
    end

endmodule

// File: tb/tb_crc32_stream.sv
// tb_crc32_stream: self-checking bench for crc32_stream (DW=32 main instance,
// DW=8 and DW=64 instances for the width-equivalence vectors).
module tb_crc32_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DW=32 instance
    logic        s_valid = 1'b0, s_ready, s_sof = 1'b0, s_eof = 1'b0, s_chk = 1'b0;
    logic [31:0] s_data = '0;
    logic [3:0]  s_keep = '0;
    logic        o_valid, o_ready = 1'b1, o_ok;
    logic [31:0] o_crc;
    logic [15:0] o_len;

    // DW=8 instance
    logic        b_valid = 1'b0, b_ready, b_sof = 1'b0, b_eof = 1'b0, b_chk = 1'b0;
    logic [7:0]  b_data = '0;
    logic [0:0]  b_keep = '1;
    logic        b_ovalid, b_ordy = 1'b1, b_ok;
    logic [31:0] b_crc;
    logic [15:0] b_len;

    // DW=64 instance
    logic        w_valid = 1'b0, w_ready, w_sof = 1'b0, w_eof = 1'b0, w_chk = 1'b0;
    logic [63:0] w_data = '0;
    logic [7:0]  w_keep = '1;
    logic        w_ovalid, w_ordy = 1'b1, w_ok;
    logic [31:0] w_crc;
    logic [15:0] w_len;

    crc32_stream #(.DW(32)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_keep(s_keep), .s_sof(s_sof), .s_eof(s_eof), .s_chk(s_chk), .o_valid(o_valid),
        .o_ready(o_ready), .o_crc(o_crc), .o_ok(o_ok), .o_len(o_len));

    crc32_stream #(.DW(8)) dut8 (
        .clk(clk), .rst(rst), .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data),
        .s_keep(b_keep), .s_sof(b_sof), .s_eof(b_eof), .s_chk(b_chk), .o_valid(b_ovalid),
        .o_ready(b_ordy), .o_crc(b_crc), .o_ok(b_ok), .o_len(b_len));

    crc32_stream #(.DW(64)) dut64 (
        .clk(clk), .rst(rst), .s_valid(w_valid), .s_ready(w_ready), .s_data(w_data),
        .s_keep(w_keep), .s_sof(w_sof), .s_eof(w_eof), .s_chk(w_chk), .o_valid(w_ovalid),
        .o_ready(w_ordy), .o_crc(w_crc), .o_ok(w_ok), .o_len(w_len));

    typedef struct packed {
        logic [31:0] crc;
        logic        ok;
        logic [15:0] len;
    } res_t;

    typedef struct {
        logic [8*43-1:0] msg;
        int              n;
        logic            chk;
        logic [31:0]     crc;
        logic            ok;
        logic [15:0]     len;
    } vec_t;

    int          n_tests = 0, n_fail = 0;
    int          stab_err = 0;
    int          cyc = 0, acc_cyc = 0, first_cyc = 0, last_cyc = 0;
    logic        rand_ordy = 1'b0, rand_gap = 1'b0;
    logic [7:0]  frame_q[$];
    res_t        exp_q[$], got_q[$];
    logic        held = 1'b0;
    res_t        held_v;
    logic [71:0] m9;
    vec_t        vecs[6];

    always @(negedge clk) cyc <= cyc + 1;

    // Result monitor: records consumed results and flags any change while stalled.
    initial forever begin
        @(negedge clk);
        #4;
        if (rst || !o_valid) begin
            held = 1'b0;
        end else begin
            if (held && (held_v != {o_crc, o_ok, o_len})) stab_err++;
            if (o_ready) begin
                got_q.push_back({o_crc, o_ok, o_len});
                held = 1'b0;
            end else begin
                held   = 1'b1;
                held_v = {o_crc, o_ok, o_len};
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required earlier completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Reference: bit-serial reflected CRC over the whole frame byte list.
    function automatic logic [31:0] model_reg();
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (frame_q[k]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ frame_q[k][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return c;
    endfunction

    task automatic push_model(input logic chk_m);
        logic [31:0] r;
        int          n;
        r = model_reg();
        n = frame_q.size();
        exp_q.push_back({r ^ 32'hFFFFFFFF, chk_m && (r == 32'hDEBB20E3),
                         (n > 65535) ? 16'hFFFF : 16'(n)});
    endtask

    task automatic next_ordy();
        if (rand_ordy) o_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic [3:0] k,
                              input logic sof, input logic eof, input logic chk_m);
        int w;
        @(negedge clk);
        if (rand_gap) begin
            while ($urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                s_chk   = 1'($urandom_range(0, 1));
                next_ordy();
                @(negedge clk);
            end
        end
        s_valid = 1'b1;
        s_data  = d;
        s_keep  = k;
        s_sof   = sof;
        s_eof   = eof;
        s_chk   = sof ? chk_m : 1'($urandom_range(0, 1));
        next_ordy();
        w = 0;
        #1;
        while (!s_ready) begin
            w++;
            if (w > 200) begin
                n_tests++;
                n_fail++;
                $display("FAIL beat_accept: s_ready low for %0d cycles, required <= 200", w);
                break;
            end
            @(negedge clk);
            next_ordy();
            #1;
        end
        @(posedge clk);
        acc_cyc = cyc;
    endtask

    task automatic drive_frame(input logic chk_m);
        int          n, nb, m, idx;
        logic [31:0] d;
        logic [3:0]  k;
        n  = frame_q.size();
        nb = (n == 0) ? 1 : (n + 3) / 4;
        for (int bt = 0; bt < nb; bt++) begin
            d = $urandom;
            k = 4'($urandom_range(0, 15));
            if (bt == nb - 1) begin
                m = n - bt * 4;
                k = '0;
                for (int l = 0; l < 4; l++) begin
                    if (l < m) k[l] = 1'b1;
                    else if (l > m) k[l] = 1'($urandom_range(0, 1));
                end
            end
            for (int l = 0; l < 4; l++) begin
                idx = bt * 4 + l;
                if (idx < n) d[8*l +: 8] = frame_q[idx];
            end
            drive_beat(d, k, bt == 0, bt == nb - 1, chk_m);
            if (bt == 0) first_cyc = acc_cyc;
        end
        last_cyc = acc_cyc;
    endtask

    task automatic load_m9();
        frame_q.delete();
        for (int k = 0; k < 9; k++) frame_q.push_back(m9[8*(8-k) +: 8]);
    endtask

    task automatic finish_frames(input string tag);
        res_t g, e;
        @(negedge clk);
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eof   = 1'b0;
        o_ready = 1'b1;
        for (int c = 0; c < 200 && got_q.size() < exp_q.size(); c++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_crc"}, g.crc, e.crc);
            chk({tag, "_ok"}, 32'(g.ok), 32'(e.ok));
            chk({tag, "_len"}, 32'(g.len), 32'(e.len));
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        int          nb, prev_last;
        logic        cm;
        logic [31:0] r;
        int          n;

        m9 = "123456789";
        vecs[0] = '{"", 0, 1'b0, 32'h00000000, 1'b0, 16'd0};
        vecs[1] = '{"a", 1, 1'b0, 32'hE8B7BE43, 1'b0, 16'd1};
        vecs[2] = '{"abc", 3, 1'b0, 32'h352441C2, 1'b0, 16'd3};
        vecs[3] = '{"123456789", 9, 1'b0, 32'hCBF43926, 1'b0, 16'd9};
        vecs[4] = '{"The quick brown fox jumps over the lazy dog", 43, 1'b0, 32'h414FA339, 1'b0, 16'd43};
        vecs[5] = '{{"123456789", 8'h26, 8'h39, 8'hF4, 8'hCB}, 13, 1'b1, 32'h2144DF1C, 1'b1, 16'd13};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_crc", o_crc, 32'd0);
        chk("rst_o_ok", 32'(o_ok), 32'd0);
        chk("rst_o_len", 32'(o_len), 32'd0);
        chk("post_rst_s_ready", 32'(s_ready), 32'd1);

        // DW=8 serial-equivalent vector with latency check
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            b_valid = 1'b1;
            b_data  = m9[8*(8-k) +: 8];
            b_sof   = (k == 0);
            b_eof   = (k == 8);
            #1;
            if (k == 8) begin
                chk("dw8_valid_before_eof_edge", 32'(b_ovalid), 32'd0);
                chk("dw8_ready", 32'(b_ready), 32'd1);
            end
            @(posedge clk);
        end
        #1;
        chk("dw8_valid_after_eof", 32'(b_ovalid), 32'd1);
        chk("dw8_crc", b_crc, 32'hCBF43926);
        chk("dw8_len", 32'(b_len), 32'd9);
        chk("dw8_ok", 32'(b_ok), 32'd0);
        @(negedge clk);
        b_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("dw8_valid_one_cycle", 32'(b_ovalid), 32'd0);

        // DW=64: one full beat plus a one-byte tail
        @(negedge clk);
        w_valid = 1'b1;
        w_sof   = 1'b1;
        w_eof   = 1'b0;
        w_keep  = 8'hFF;
        for (int l = 0; l < 8; l++) w_data[8*l +: 8] = m9[8*(8-l) +: 8];
        @(negedge clk);
        w_sof  = 1'b0;
        w_eof  = 1'b1;
        w_keep = 8'h01;
        w_data = {$urandom, $urandom};
        w_data[7:0] = m9[7:0];
        @(posedge clk);
        #1;
        chk("dw64_valid", 32'(w_ovalid), 32'd1);
        chk("dw64_crc", w_crc, 32'hCBF43926);
        chk("dw64_len", 32'(w_len), 32'd9);
        @(negedge clk);
        w_valid = 1'b0;

        // Table vectors, back-to-back at full rate
        prev_last = 0;
        for (int i = 0; i < 6; i++) begin
            frame_q.delete();
            for (int k = 0; k < vecs[i].n; k++) frame_q.push_back(vecs[i].msg[8*(vecs[i].n-1-k) +: 8]);
            exp_q.push_back({vecs[i].crc, vecs[i].ok, vecs[i].len});
            drive_frame(vecs[i].chk);
            nb = (vecs[i].n == 0) ? 1 : (vecs[i].n + 3) / 4;
            chk("beat_rate", 32'(last_cyc - first_cyc), 32'(nb - 1));
            if (i > 0) chk("frame_gap", 32'(first_cyc - prev_last), 32'd1);
            prev_last = last_cyc;
        end
        finish_frames("vec");

        // Check mode: 60 bytes + FCS, then corrupted copy
        frame_q.delete();
        for (int k = 0; k < 60; k++) frame_q.push_back(8'($urandom_range(0, 255)));
        r = model_reg() ^ 32'hFFFFFFFF;
        for (int k = 0; k < 4; k++) frame_q.push_back(r[8*k +: 8]);
        exp_q.push_back({32'h2144DF1C, 1'b1, 16'd64});
        drive_frame(1'b1);
        frame_q[5] = frame_q[5] ^ 8'h01;
        push_model(1'b1);
        drive_frame(1'b1);
        finish_frames("chk");

        // Back-pressure: result held, SOF beat waits, then accepted with o_ready
        o_ready = 1'b0;
        frame_q.delete();
        frame_q.push_back("a");
        frame_q.push_back("b");
        frame_q.push_back("c");
        exp_q.push_back({32'h352441C2, 1'b0, 16'd3});
        drive_frame(1'b0);
        @(negedge clk);
        s_valid = 1'b0;
        for (int c = 0; c < 20 && !o_valid; c++) @(negedge clk);
        chk("bp_valid", 32'(o_valid), 32'd1);
        s_valid = 1'b1;
        s_sof   = 1'b1;
        s_eof   = 1'b1;
        s_keep  = 4'b0001;
        s_data  = {24'hA5A5A5, "a"};
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_s_ready_low", 32'(s_ready), 32'd0);
            chk("bp_o_valid_held", 32'(o_valid), 32'd1);
            @(negedge clk);
        end
        o_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(s_ready), 32'd1);
        exp_q.push_back({32'hE8B7BE43, 1'b0, 16'd1});
        @(posedge clk);
        finish_frames("bp");
        chk("hold_stable", 32'(stab_err), 32'd0);

        // Beats without SOF while idle are dropped
        drive_beat(32'h11223344, 4'hF, 1'b0, 1'b0, 1'b0);
        drive_beat(32'h55667788, 4'hF, 1'b0, 1'b1, 1'b0);
        finish_frames("idle_drop");

        // SOF mid-frame aborts the running frame
        drive_beat(32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 1'b0);
        drive_beat(32'hCAFEF00D, 4'hF, 1'b0, 1'b0, 1'b0);
        load_m9();
        exp_q.push_back({32'hCBF43926, 1'b0, 16'd9});
        drive_frame(1'b0);
        finish_frames("abort");

        // Reset drops a pending result
        o_ready = 1'b0;
        frame_q.delete();
        frame_q.push_back("a");
        drive_frame(1'b0);
        @(negedge clk);
        s_valid = 1'b0;
        for (int c = 0; c < 20 && !o_valid; c++) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_pending_s_ready", 32'(s_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        o_ready = 1'b1;
        #1;
        chk("rst_pending_valid", 32'(o_valid), 32'd0);
        chk("rst_pending_crc", o_crc, 32'd0);
        chk("rst_pending_len", 32'(o_len), 32'd0);

        // Reset mid-frame, then a clean frame
        drive_beat({m9[47:40], m9[55:48], m9[63:56], m9[71:64]}, 4'hF, 1'b1, 1'b0, 1'b0);
        drive_beat({m9[15:8], m9[23:16], m9[31:24], m9[39:32]}, 4'hF, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        s_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        s_valid = 1'b1;
        s_sof   = 1'b0;
        s_eof   = 1'b1;
        s_keep  = 4'b0001;
        s_data  = {24'd0, m9[7:0]};
        @(negedge clk);
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid_no_result", 32'(o_valid), 32'd0);
        load_m9();
        exp_q.push_back({32'hCBF43926, 1'b0, 16'd9});
        drive_frame(1'b0);
        finish_frames("rst_mid");

        // Randomized frames with gaps, back-pressure and check mode
        rand_ordy = 1'b1;
        rand_gap  = 1'b1;
        for (int f = 0; f < 40; f++) begin
            n  = $urandom_range(0, 70);
            cm = 1'($urandom_range(0, 1));
            frame_q.delete();
            for (int k = 0; k < n; k++) frame_q.push_back(8'($urandom_range(0, 255)));
            if (cm && $urandom_range(0, 1) == 1) begin
                r = model_reg() ^ 32'hFFFFFFFF;
                for (int k = 0; k < 4; k++) frame_q.push_back(r[8*k +: 8]);
            end
            push_model(cm);
            drive_frame(cm);
        end
        finish_frames("rand");
        rand_ordy = 1'b0;
        rand_gap  = 1'b0;

        // Length saturation
        frame_q.delete();
        for (int k = 0; k < 65540; k++) frame_q.push_back(8'($urandom_range(0, 255)));
        push_model(1'b0);
        drive_frame(1'b0);
        finish_frames("sat");
        chk("hold_stable_final", 32'(stab_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/crc32_stream.md
# crc32_stream

Parametrised Ethernet CRC‑32 engine for the frame datapath. It accepts a valid/ready byte stream of configurable width with start/end‑of‑frame markers and a byte‑keep mask. Per frame it either generates the FCS or checks a received FCS. It sits beside the MAC TX/RX framers and replaces per‑byte CRC registers where beats wider than 8 bits are needed.

## Interface
Parameters:
- DW, 32, data beat width in bits; legal values are 8, 16, 32, 64.
- INIT, 32'hFFFFFFFF, CRC register preset loaded at each SOF.
- XOROUT, 32'hFFFFFFFF, XOR applied to the register to form o_crc.
- RESIDUE, 32'hDEBB20E3, register value (before XOROUT) that indicates a good frame in check mode.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active‑high reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_data  in  DW  beat data; byte 0 is in [7:0] and is first on the wire.
- s_keep  in  DW/8  byte enables, honoured on the EOF beat only.
- s_sof  in  1  first beat of a frame.
- s_eof  in  1  last beat of a frame.
- s_chk  in  1  mode, sampled on the SOF beat: 0 = generate, 1 = check.
- o_valid  out  1  frame result valid.
- o_ready  in  1  result consumed when o_valid && o_ready.
- o_crc  out  32  final FCS, equal to register ^ XOROUT.
- o_ok  out  1  check mode: register == RESIDUE; always 0 in generate mode.
- o_len  out  16  bytes processed in the frame, saturating at 16'hFFFF.

## Operation
- CRC definition:
  - Reflected polynomial 0xEDB88320, equivalent to x32+x26+x23+x22+x16+x12+x11+x10+x8+x7+x5+x4+x2+x1+1.
  - Bits are processed LSB‑first within each byte, bytes in ascending lane order.
- Next‑state logic is one combinational fold of up to DW/8 bytes per cycle. A byte with keep=0 leaves the register unchanged.
- State machine:
  - IDLE → RUN on an accepted beat with sof=1 and eof=0.
  - IDLE → DONE on an accepted beat with sof=1 and eof=1 (single‑beat frame).
  - RUN → DONE on an accepted beat with eof=1.
  - DONE → IDLE when the result is consumed. If a SOF beat is accepted in that same cycle, the next state is RUN (or DONE if that beat also has eof=1).
- SOF beat: the register is loaded from INIT before its bytes are folded; the length counter restarts; s_chk is latched.
- Accepted beat in IDLE without sof: discarded; no state change.
- Accepted sof beat while in RUN: the current frame is aborted with no result, and the new frame starts.
- Non‑EOF beats: all DW/8 bytes are used; s_keep is ignored.
- EOF beat: s_keep must be contiguous from lane 0.
  - Non‑contiguous keep is unsupported; only lanes below the first 0 are used.
  - keep = 0 contributes zero bytes.
- o_len is the sum of bytes used in the frame, saturating at 16'hFFFF.
- DW=8 behaves byte‑for‑byte identically to a serial byte‑wise CRC‑32.

## Timing
- Reset values:
  - o_valid=0, o_crc=0, o_ok=0, o_len=0.
  - State is IDLE and the register equals INIT.
  - s_ready=0 while rst=1.
- s_ready = !rst && (!o_valid || o_ready). This is combinational; no bubble is required between frames.
- Latency: o_valid rises on the cycle after the EOF beat is accepted.
- While o_valid=1: o_crc, o_ok and o_len are held stable until o_valid && o_ready.
- Throughput: one beat per cycle when o_ready is held high.
- rst asserted mid‑frame: the frame is lost and a pending result is dropped; all outputs return to reset values on the next edge.
- s_chk change mid‑frame: ignored.

## Test plan
- DW=8, ASCII "123456789", generate mode, o_ready=1 → o_crc=32'hCBF43926, o_len=9, o_ok=0; o_valid is high exactly one cycle after the EOF beat.
- DW=32, the same string in three beats, last beat keep=4'b0001 → o_crc=32'hCBF43926, o_len=9. Repeat at DW=64 with last keep=8'h01 and expect the same result.
- Check mode, DW=32, 60‑byte frame followed by its FCS bytes LSB‑first → o_ok=1, o_len=64. Flip data bit 0 of byte 5 → o_ok=0.
- Back‑pressure: hold o_ready=0 for 3 cycles after a result. Expect s_ready=0 for those cycles, o_crc stable, and no beats consumed. Then assert o_ready together with the next SOF beat: it is accepted in that same cycle.
- Abort and drop:
  - Beats without sof while IDLE → no o_valid.
  - SOF mid‑frame followed by "123456789" → a single result, 32'hCBF43926.
- Reset: assert rst for 1 cycle in the middle of a frame → o_valid=0 and no result. The next full "123456789" frame yields 32'hCBF43926.
